// File: rtl/difficulty_pkg.sv
// Shared types and default timing constants for the difficulty timebase.
package difficulty_pkg;

  typedef enum logic {
    RUN       = 1'b0,
    WAIT_EDGE = 1'b1
  } state_t;

  localparam int CLK_HZ    = 100_000_000;
  localparam int EASY_HALF = CLK_HZ / 4;    // 2 Hz square
  localparam int HARD_HALF = CLK_HZ / 16;   // 8 Hz square
  localparam int DB_CYCLES = CLK_HZ / 100;  // 10 ms

  // Bits needed to count 0..max(a,b)-1, never less than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchronizer followed by a stability counter for the raw switch.
module sw_debounce #(
  parameter int DB_CYCLES = difficulty_pkg::DB_CYCLES
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic SW,
  output logic SW_DB
);
  import difficulty_pkg::*;

  localparam int DW = cnt_width(DB_CYCLES, 1);
  localparam logic [DW-1:0] DB_LIM = DW'(DB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [DW-1:0] db_cnt;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      SW_DB  <= 1'b0;
      db_cnt <= '0;
    end else begin
      s1 <= SW;
      s2 <= s1;
      // Any sample agreeing with the accepted level restarts the stability count.
      if (s2 == SW_DB) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LIM) begin
        SW_DB  <= s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/difficulty_tick_gen.sv
// Game-rate timebase: tick pulse and square wave whose rate follows the
// debounced difficulty switch, with changes applied only on a tick boundary.
module difficulty_tick_gen #(
  parameter int EASY_HALF = difficulty_pkg::EASY_HALF,
  parameter int HARD_HALF = difficulty_pkg::HARD_HALF,
  parameter int DB_CYCLES = difficulty_pkg::DB_CYCLES
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic SW,
  input  logic EN,
  output logic TICK,
  output logic SQ,
  output logic HARD,
  output logic PEND
);
  import difficulty_pkg::*;

  localparam int CW = cnt_width(EASY_HALF, HARD_HALF);
  localparam logic [CW-1:0] EASY_LIM = CW'(EASY_HALF - 1);
  localparam logic [CW-1:0] HARD_LIM = CW'(HARD_HALF - 1);

  logic          sw_db;
  logic [CW-1:0] cnt;
  logic [CW-1:0] lim;
  logic          wrap;
  state_t        state;

  sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_debounce (
    .CLK   (CLK),
    .RST_N (RST_N),
    .SW    (SW),
    .SW_DB (sw_db)
  );

  // The limit tracks the applied difficulty, so a change wraps on the old limit.
  assign lim  = HARD ? HARD_LIM : EASY_LIM;
  assign wrap = EN && (cnt == lim);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt   <= '0;
      state <= RUN;
      TICK  <= 1'b0;
      SQ    <= 1'b0;
      HARD  <= 1'b0;
      PEND  <= 1'b0;
    end else begin
      TICK <= wrap;
      if (wrap) begin
        cnt <= '0;
        SQ  <= ~SQ;
      end else if (EN) begin
        cnt <= cnt + CW'(1);
      end

      case (state)
        RUN: begin
          if (sw_db != HARD) begin
            state <= WAIT_EDGE;
            PEND  <= 1'b1;
          end
        end
        WAIT_EDGE: begin
          // A switch that settles back before the boundary cancels the request.
          if (sw_db == HARD) begin
            state <= RUN;
            PEND  <= 1'b0;
          end else if (wrap) begin
            HARD  <= sw_db;
            state <= RUN;
            PEND  <= 1'b0;
          end
        end
        default: begin
          state <= RUN;
          PEND  <= 1'b0;
        end
      endcase
    end
  end

endmodule
